// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// sequencer state type and the size-to-byte-count helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_8  = 2'b00;
  localparam logic [1:0] SIZE_16 = 2'b01;
  localparam logic [1:0] SIZE_32 = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Number of bytes touched by an access of the given size; the illegal
  // encoding reports 4 so range checks stay conservative.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_8:  n = 3'd1;
      SIZE_16: n = 3'd2;
      SIZE_32: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of a memory request: illegal size,
// misalignment for 16/32-bit accesses, or an access running past the end
// of the memory all flag an error.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SIZE = 512
) (
  input  logic [1:0]      size_i,
  input  logic [XLEN-1:0] addr_i,
  output logic            err_o
);

  // One extra bit so addr + bytes cannot wrap around at the top of the space.
  localparam logic [XLEN:0] LIMIT = (XLEN+1)'(SIZE * 4);

  logic [2:0]    bytes_s;
  logic [XLEN:0] end_addr_s;
  logic          misaligned_s;

  // Derive byte count, exclusive end address and alignment fault.
  always_comb begin
    bytes_s    = size_bytes(size_i);
    end_addr_s = {1'b0, addr_i} + {{(XLEN-2){1'b0}}, bytes_s};
    case (size_i)
      SIZE_8:  misaligned_s = 1'b0;
      SIZE_16: misaligned_s = addr_i[0];
      SIZE_32: misaligned_s = |addr_i[1:0];
      default: misaligned_s = 1'b1;
    endcase
    err_o = misaligned_s | (end_addr_s > LIMIT);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-cycle
// data memory. Port 0 is the CPU load/store unit, port 1 the debug/DMA
// loader. A request is accepted in IDLE, issued to memory for one cycle
// (memory acts on the mid-cycle negedge) and completed at the next posedge.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SIZE = 512
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req,
  input  logic            p0_write,
  input  logic [1:0]      p0_size,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_done,
  output logic            p0_err,
  output logic [XLEN-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_write,
  input  logic [1:0]      p1_size,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_done,
  output logic            p1_err,
  output logic [XLEN-1:0] p1_rdata,
  output logic            mem_en,
  output logic            mem_write,
  output logic [1:0]      mem_size,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  state_e          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic            owner_q, owner_d;
  logic            err_q, err_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_write_q, mem_write_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
  logic            p0_done_q, p0_done_d, p1_done_q, p1_done_d;
  logic            p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [XLEN-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  logic            any_req_s, both_req_s, sel_port_s, sel_write_s, sel_err_s;
  logic [1:0]      sel_size_s;
  logic [XLEN-1:0] sel_addr_s, sel_wdata_s;
  logic [XLEN-1:0] load_data_s;

  // Pick the candidate port: a lone requester wins, a tie goes to the port
  // that did not win the previous tie.
  always_comb begin
    any_req_s  = p0_req | p1_req;
    both_req_s = p0_req & p1_req;
    if (both_req_s) begin
      sel_port_s = ~rr_last_q;
    end else if (p1_req) begin
      sel_port_s = 1'b1;
    end else begin
      sel_port_s = 1'b0;
    end
    if (sel_port_s) begin
      sel_write_s = p1_write;
      sel_size_s  = p1_size;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_write_s = p0_write;
      sel_size_s  = p0_size;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
  end

  dmem_req_check #(
    .XLEN (XLEN),
    .SIZE (SIZE)
  ) u_req_check (
    .size_i (sel_size_s),
    .addr_i (sel_addr_s),
    .err_o  (sel_err_s)
  );

  // Stores and rejected requests return zero; only a good load returns data.
  always_comb begin
    if (err_q | mem_write_q) begin
      load_data_s = {XLEN{1'b0}};
    end else begin
      load_data_s = mem_rdata;
    end
  end

  // Sequencer next state: accept in IDLE, complete in ISSUE. Pulses default
  // low; mem_* fields hold their values unless a new request is latched.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    err_d       = err_q;
    mem_en_d    = 1'b0;
    mem_write_d = mem_write_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_gnt_d    = 1'b0;
    p1_gnt_d    = 1'b0;
    p0_done_d   = 1'b0;
    p1_done_d   = 1'b0;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    p0_rdata_d  = {XLEN{1'b0}};
    p1_rdata_d  = {XLEN{1'b0}};
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d     = ISSUE;
          owner_d     = sel_port_s;
          err_d       = sel_err_s;
          mem_en_d    = ~sel_err_s;
          mem_write_d = sel_write_s;
          mem_size_d  = sel_size_s;
          mem_addr_d  = sel_addr_s;
          mem_wdata_d = sel_wdata_s;
          if (both_req_s) begin
            rr_last_d = sel_port_s;
          end else begin
            rr_last_d = rr_last_q;
          end
          if (sel_port_s) begin
            p1_gnt_d = 1'b1;
          end else begin
            p0_gnt_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = IDLE;
        if (owner_q) begin
          p1_done_d  = 1'b1;
          p1_err_d   = err_q;
          p1_rdata_d = load_data_s;
        end else begin
          p0_done_d  = 1'b1;
          p0_err_d   = err_q;
          p0_rdata_d = load_data_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and hands the
  // first tie to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_done_q   <= 1'b0;
      p1_done_q   <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= {XLEN{1'b0}};
      p1_rdata_q  <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_write_q <= mem_write_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_gnt_q    <= p0_gnt_d;
      p1_gnt_q    <= p1_gnt_d;
      p0_done_q   <= p0_done_d;
      p1_done_q   <= p1_done_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_write = mem_write_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-array memory stub answers the
// DUT, a reference model predicts grant order, errors and load data, and a
// monitor compares every grant/done against the predicted queue.
module tb_dmem_arbiter;

  localparam int XLEN  = 32;
  localparam int SIZE  = 512;
  localparam int DEPTH = SIZE * 4;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic p0_req, p0_write, p1_req, p1_write;
  logic [1:0] p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic mem_en, mem_write;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem_bytes [DEPTH];
  logic [7:0] ref_mem   [DEPTH];
  exp_t gnt_q [$];
  exp_t done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_gnt_cyc = 0;
  bit   tie_last = 1'b1;

  dmem_arbiter #(.XLEN(XLEN), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_write(p0_write), .p0_size(p0_size), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_size(p1_size), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err),
    .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single-cycle memory stub: acts on the negedge while enabled.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_write) begin
        for (int i = 0; i < nbytes(mem_size); i++)
          if (int'(mem_addr) + i < DEPTH) mem_bytes[int'(mem_addr) + i] = mem_wdata[8*i +: 8];
      end else begin
        mem_rdata = 32'd0;
        for (int i = 0; i < nbytes(mem_size); i++)
          if (int'(mem_addr) + i < DEPTH) mem_rdata[8*i +: 8] = mem_bytes[int'(mem_addr) + i];
      end
    end
  end

  // Reference model: legality from plain arithmetic, memory as a byte array.
  task automatic predict(input bit port, input txn_t t, input bit want_done);
    exp_t   e;
    int     n;
    longint a;
    n = nbytes(t.sz);
    a = longint'(t.a);
    e.port = port; e.w = t.w; e.sz = t.sz; e.a = t.a; e.d = t.d;
    e.err = (t.sz == 2'b11) || ((a % n) != 0) || (a + n > DEPTH);
    e.rdata = 32'd0;
    if (!e.err) begin
      for (int i = 0; i < n; i++) begin
        if (t.w) ref_mem[int'(a) + i] = t.d[8*i +: 8];
        else     e.rdata[8*i +: 8] = ref_mem[int'(a) + i];
      end
    end
    gnt_q.push_back(e);
    if (want_done) done_q.push_back(e);
  endtask

  // Monitor: compare every grant and completion against the predicted queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (p0_gnt === 1'b1 || p1_gnt === 1'b1 || p0_done === 1'b1 || p1_done === 1'b1)
      chk("exclusive", {29'd0, p0_gnt & p1_gnt, p0_done & p1_done, p0_err & p1_err}, 32'd0);
    if (p0_gnt === 1'b1 || p1_gnt === 1'b1) begin
      last_gnt_cyc = cyc;
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", 32'd1, 32'd0);
      end else begin
        e = gnt_q.pop_front();
        chk("gnt_port",  32'(p1_gnt),    32'(e.port));
        chk("mem_en",    32'(mem_en),    32'(!e.err));
        chk("mem_write", 32'(mem_write), 32'(e.w));
        chk("mem_size",  32'(mem_size),  32'(e.sz));
        chk("mem_addr",  mem_addr,       e.a);
        chk("mem_wdata", mem_wdata,      e.d);
      end
    end else if (rst === 1'b0) begin
      chk("mem_en_idle", 32'(mem_en), 32'd0);
    end
    if (p0_done === 1'b1 || p1_done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = done_q.pop_front();
        chk("done_port",    32'(p1_done), 32'(e.port));
        chk("done_latency", 32'(cyc),     32'(last_gnt_cyc + 1));
        chk("done_err",     32'(e.port ? p1_err : p0_err), 32'(e.err));
        chk("done_rdata",   e.port ? p1_rdata : p0_rdata,   e.rdata);
        chk("other_rdata",  e.port ? p0_rdata : p1_rdata,   32'd0);
      end
    end else if (rst === 1'b0) begin
      chk("idle_outs", {30'd0, p0_err | p1_err, |(p0_rdata | p1_rdata)}, 32'd0);
    end
  end

  // One round: raise the chosen requests together, drop each on its grant,
  // and check grant timing (winner first edge, loser two cycles later).
  task automatic round(input bit u0, input bit u1, input txn_t t0, input txn_t t1);
    bit win;
    int g0, g1;
    if (u0 && u1) begin
      win = ~tie_last;
      tie_last = win;
      predict(win, win ? t1 : t0, 1'b1);
      predict(~win, win ? t0 : t1, 1'b1);
    end else begin
      win = u1;
      predict(win, win ? t1 : t0, 1'b1);
    end
    p0_write = t0.w; p0_size = t0.sz; p0_addr = t0.a; p0_wdata = t0.d;
    p1_write = t1.w; p1_size = t1.sz; p1_addr = t1.a; p1_wdata = t1.d;
    p0_req = u0; p1_req = u1;
    g0 = 0; g1 = 0;
    for (int c = 1; c <= 12 && (p0_req || p1_req); c++) begin
      @(posedge clk); #1;
      if (p0_req && p0_gnt) begin g0 = c; p0_req = 1'b0; end
      if (p1_req && p1_gnt) begin g1 = c; p1_req = 1'b0; end
    end
    if (p0_req || p1_req) begin
      chk("gnt_timeout", 32'd1, 32'd0);
      p0_req = 1'b0; p1_req = 1'b0;
    end
    if (u0) chk("gnt_cycle_p0", 32'(g0), (u1 && win)  ? 32'd3 : 32'd1);
    if (u1) chk("gnt_cycle_p1", 32'(g1), (u0 && !win) ? 32'd3 : 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic txn_t mk(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.w = w; t.sz = sz; t.a = a; t.d = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r, n;
    t.w  = 1'($urandom_range(0, 1));
    r    = $urandom_range(0, 15);
    t.sz = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    n    = nbytes(t.sz);
    r    = $urandom_range(0, 9);
    if (r == 0)      t.a = 32'($urandom_range(DEPTH - 4, DEPTH + 3));
    else if (r == 1) t.a = 32'($urandom_range(0, DEPTH - 1));
    else if (r < 6)  t.a = 32'($urandom_range(0, 63)) & ~(32'(n) - 32'd1);
    else             t.a = 32'($urandom_range(0, DEPTH - 1)) & ~(32'(n) - 32'd1);
    t.d = $urandom();
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t nul, l;
    int   errs, sel;
    nul = mk(1'b0, 2'b10, 32'd0, 32'd0);
    rst = 1'b1;
    p0_req = 1'b0; p0_write = 1'b0; p0_size = 2'b00; p0_addr = 32'd0; p0_wdata = 32'd0;
    p1_req = 1'b0; p1_write = 1'b0; p1_size = 2'b00; p1_addr = 32'd0; p1_wdata = 32'd0;
    mem_rdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_bytes[i] = 8'($urandom());
      ref_mem[i]   = mem_bytes[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem_bytes[i] = 8'h11; ref_mem[i] = 8'h11;
      mem_bytes[i+4] = 8'h22; ref_mem[i+4] = 8'h22;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {22'd0, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_en, mem_write, mem_size}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_rdata", p0_rdata | p1_rdata | mem_wdata, 32'd0);
    rst = 1'b0;

    // Word store then load back through port 0.
    round(1'b1, 1'b0, mk(1'b1, 2'b10, 32'h10, 32'hDEADBEEF), nul);
    round(1'b1, 1'b0, mk(1'b0, 2'b10, 32'h10, 32'h0), nul);
    // Two ties: port 0 wins first, port 1 wins the next tie.
    round(1'b1, 1'b1, mk(1'b0, 2'b10, 32'h0, 32'h0), mk(1'b0, 2'b10, 32'h4, 32'h0));
    round(1'b1, 1'b1, mk(1'b0, 2'b10, 32'h0, 32'h0), mk(1'b0, 2'b10, 32'h4, 32'h0));
    // Misaligned word load on port 1.
    round(1'b0, 1'b1, nul, mk(1'b0, 2'b10, 32'h6, 32'h0));
    // Last byte in range, then a halfword running past the end.
    round(1'b1, 1'b0, mk(1'b1, 2'b00, 32'h7FF, 32'hAB), nul);
    round(1'b1, 1'b0, mk(1'b1, 2'b01, 32'h7FF, 32'h1234), nul);
    round(1'b1, 1'b0, mk(1'b0, 2'b00, 32'h7FF, 32'h0), nul);
    // Illegal size store leaves memory untouched.
    round(1'b1, 1'b0, mk(1'b1, 2'b11, 32'h20, 32'h55555555), nul);
    round(1'b1, 1'b0, mk(1'b0, 2'b10, 32'h20, 32'h0), nul);

    // Reset during the issue cycle of a port 1 load: no done pulse.
    l = mk(1'b0, 2'b10, 32'h4, 32'h0);
    predict(1'b1, l, 1'b0);
    p1_write = l.w; p1_size = l.sz; p1_addr = l.a; p1_wdata = l.d;
    p1_req = 1'b1;
    @(posedge clk); #1;
    chk("rst_case_gnt", 32'(p1_gnt), 32'd1);
    p1_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_case_ctrl", {22'd0, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_en, mem_write, mem_size}, 32'd0);
    chk("rst_case_data", p0_rdata | p1_rdata | mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;
    tie_last = 1'b1;
    round(1'b1, 1'b0, mk(1'b0, 2'b10, 32'h10, 32'h0), nul);

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(1, 3);
      round(sel[0], sel[1], rand_txn(), rand_txn());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("gnt_queue_empty",  32'(gnt_q.size()),  32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem_bytes[i] !== ref_mem[i]) errs++;
    chk("mem_final", 32'(errs), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-cycle data memory.
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Round-robin grant between the ports.
- Checks size, alignment and range before issuing; drives the memory's en/write/size/addr/data; captures read data and returns it per port.

Parameters:
- XLEN, 32, data/address width.
- SIZE, 512, memory depth in 32-bit words; valid byte addresses are 0 .. SIZE*4-1.

Ports:
- clk  in  1  system clock; memory samples on negedge, arbiter on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  request; held high with fields stable until gnt is seen.
- p0_write / p1_write  in  1  1=store, 0=load.
- p0_size / p1_size  in  2  00=8-bit, 01=16-bit, 10=32-bit, 11 illegal.
- p0_addr / p1_addr  in  XLEN  byte address.
- p0_wdata / p1_wdata  in  XLEN  store data, low bytes used.
- p0_gnt / p1_gnt  out  1  one-cycle pulse: request accepted.
- p0_done / p1_done  out  1  one-cycle pulse: transaction complete (load, store or error).
- p0_err / p1_err  out  1  valid with done: request rejected, memory not touched.
- p0_rdata / p1_rdata  out  XLEN  raw 32-bit load word, valid with done; cpu sign-extends.
- mem_en  out  1  memory enable.
- mem_write  out  1  memory write.
- mem_size  out  2  memory access size.
- mem_addr  out  XLEN  memory byte address.
- mem_wdata  out  XLEN  memory store data.
- mem_rdata  in  XLEN  memory data_out, valid after the negedge of an issue cycle.

Behaviour:
- Reset: state=IDLE; all outputs 0; rr_last=1, so port 0 wins the first tie.
- States: IDLE, ISSUE. Transitions are taken only on posedge.
- IDLE, no req: stay IDLE; mem_en=0.
- IDLE, req present: select port.
  - Only one requesting: that port.
  - Both requesting: the port != rr_last; set rr_last = selected.
  - Latch selected write/size/addr/wdata into the mem_* registers.
  - Pulse gnt for the selected port; go to ISSUE.
- Error check at selection: size==11; size==10 with addr[1:0]!=0; size==01 with addr[0]!=0; addr+bytes > SIZE*4.
  - On error: mem_en stays 0 during ISSUE; latch err flag.
  - Otherwise: mem_en=1 during ISSUE only.
- ISSUE: memory acts on the mid-cycle negedge. At the next posedge:
  - Pulse done for the owning port.
  - err = latched flag.
  - rdata = mem_rdata for a good load; 0 for stores and errors.
  - Clear mem_en; go to IDLE.
- Latency and throughput:
  - req sampled at edge E0 -> gnt high E0..E1; done/rdata high E1..E2.
  - One transaction per 2 cycles; the next acceptance is earliest at E2.
- Requesters drop or change req on the edge where gnt is seen. A req still high while state=ISSUE is ignored. The losing port keeps req high and is granted at E2.
- gnt, done and err are never asserted to both ports in the same cycle. rdata of the non-owning port holds 0.
- Reset mid-operation: rst during ISSUE returns to IDLE with no done pulse. A store already applied at that cycle's negedge remains in memory. This is documented, not an error.
- mem_write, mem_size, mem_addr and mem_wdata hold their last values while mem_en=0. The memory ignores them.

Decomposition:
- Shared package dmem_pkg:
  - SIZE_8/SIZE_16/SIZE_32 encodings (00/01/10).
  - State enum IDLE/ISSUE.
  - Function size_bytes(size) returning 1/2/4.
- One sub-module: dmem_req_check. Purely combinational: size, addr -> err. Instantiated once on the selected request.

Test Plan:
- p0 store size=10 addr=0x10 wdata=0xDEADBEEF, then p0 load addr=0x10 -> mem_en one cycle each; store done err=0; load done with p0_rdata=0xDEADBEEF exactly 2 edges after req.
- p0 and p1 both hold req for loads to 0x0 and 0x4 (preloaded 0x11111111, 0x22222222) -> p0 granted first, p1 at +2 cycles; rdata 0x11111111 then 0x22222222. Repeat the tie -> p1 wins next.
- p1 load size=10 addr=0x6 -> p1_gnt, then p1_done with p1_err=1, p1_rdata=0, mem_en never high.
- p0 store size=00 addr=0x7FF data=0xAB (SIZE=512), then size=01 addr=0x7FF -> first ok; second err=1 (out of range).
- p0 store size=11 -> err=1; memory contents unchanged on readback.
- rst asserted during ISSUE of a p1 load -> no p1_done; all outputs 0 next cycle; a following p0 request is granted normally.
